// File: rtl/hdlc_tx_scheduler_pkg.sv
// Shared types and constants for the HDLC Tx frame scheduler.
package hdlc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    START,
    WAIT,
    ABORT,
    RELEASE
  } sched_state_t;

  localparam int MAX_FRAME_DEFAULT = 126;
  localparam int TX_BUF_BYTES      = 128;

endpackage

// File: rtl/hdlc_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after lastServed, wrapping.
module rr_arbiter #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] lastServed,
  output logic [WIDTH-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan from lastServed+1 around the ring; first active request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      idx = IDX_W'((int'(lastServed) + i) % WIDTH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdlc_tx_scheduler.sv
// Shares one HDLC transmitter among NUM_REQ frame sources: arbitrates,
// streams the winner's payload into the Tx buffer, starts transmission and
// waits for completion, forwarding requester aborts as frame aborts.
module hdlc_tx_scheduler
  import hdlc_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_FRAME = MAX_FRAME_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_REQ-1:0]      Req,
  input  logic [NUM_REQ-1:0][6:0] ReqLen,
  input  logic [NUM_REQ-1:0][7:0] ReqData,
  input  logic [NUM_REQ-1:0]      ReqValid,
  output logic [NUM_REQ-1:0]      ReqReady,
  input  logic [NUM_REQ-1:0]      ReqAbort,
  output logic [NUM_REQ-1:0]      Grant,
  output logic [NUM_REQ-1:0]      Done,
  output logic [NUM_REQ-1:0]      Aborted,
  output logic [NUM_REQ-1:0]      Err,
  output logic                    Tx_WrBuff,
  output logic [7:0]              Tx_DataIn,
  input  logic                    Tx_Full,
  output logic                    Tx_Enable,
  output logic                    Tx_AbortFrame,
  input  logic                    Tx_Done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // A frame can never exceed the buffer space left after the two FCS bytes.
  localparam int MAX_LEN = (MAX_FRAME < TX_BUF_BYTES - 2) ? MAX_FRAME : TX_BUF_BYTES - 2;

  sched_state_t       state;
  logic [IDX_W-1:0]   lastServed;
  logic [IDX_W-1:0]   gIdx;
  logic [IDX_W-1:0]   pickIdx;
  logic [NUM_REQ-1:0] pickOH;
  logic [6:0]         pickLen;
  logic [6:0]         lenQ;
  logic [6:0]         cnt;
  logic               txDonePrev;
  logic               lenBad;
  logic               abortReq;
  logic               xfer;

  rr_arbiter #(
    .WIDTH(NUM_REQ)
  ) uArb (
    .req       (Req),
    .lastServed(lastServed),
    .grant     (pickOH)
  );

  // Convert the arbiter's one-hot pick into an index for muxing.
  always_comb begin
    pickIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickOH[i]) pickIdx = IDX_W'(i);
    end
  end

  assign pickLen  = ReqLen[pickIdx];
  assign lenBad   = (pickLen == 7'd0) || (int'(pickLen) > MAX_LEN);
  assign abortReq = ReqAbort[gIdx] && (state inside {LOAD, START, WAIT});

  // Byte pass-through from the owner to the Tx buffer; an abort blocks the
  // transfer in the same cycle so a racing last byte is never written.
  always_comb begin
    ReqReady  = '0;
    Tx_WrBuff = 1'b0;
    Tx_DataIn = '0;
    xfer      = 1'b0;
    if (state == LOAD && !Tx_Full && !ReqAbort[gIdx]) begin
      ReqReady[gIdx] = 1'b1;
      if (ReqValid[gIdx]) begin
        xfer      = 1'b1;
        Tx_WrBuff = 1'b1;
        Tx_DataIn = ReqData[gIdx];
      end
    end
  end

  // Scheduler FSM with registered grant and one-cycle status pulses.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      lastServed    <= IDX_W'(NUM_REQ - 1);
      gIdx          <= '0;
      lenQ          <= '0;
      cnt           <= '0;
      txDonePrev    <= 1'b0;
      Grant         <= '0;
      Done          <= '0;
      Aborted       <= '0;
      Err           <= '0;
      Tx_Enable     <= 1'b0;
      Tx_AbortFrame <= 1'b0;
    end else begin
      txDonePrev    <= Tx_Done;
      Done          <= '0;
      Aborted       <= '0;
      Err           <= '0;
      Tx_Enable     <= 1'b0;
      Tx_AbortFrame <= 1'b0;
      case (state)
        IDLE: begin
          if (Tx_Done && (|Req)) state <= ARB;
        end
        ARB: begin
          cnt  <= '0;
          lenQ <= pickLen;
          gIdx <= pickIdx;
          if (pickOH == '0) begin
            state <= IDLE;
          end else if (lenBad) begin
            // Advance the pointer so a malformed request cannot starve others.
            Err        <= pickOH;
            lastServed <= pickIdx;
            state      <= IDLE;
          end else begin
            Grant <= pickOH;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abortReq) begin
            Tx_AbortFrame <= 1'b1;
            state         <= ABORT;
          end else if (xfer) begin
            cnt <= cnt + 7'd1;
            if ((cnt + 7'd1) == lenQ) begin
              Tx_Enable <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          if (abortReq) begin
            Tx_AbortFrame <= 1'b1;
            state         <= ABORT;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abortReq) begin
            Tx_AbortFrame <= 1'b1;
            state         <= ABORT;
          end else if (Tx_Done && !txDonePrev) begin
            Done  <= Grant;
            state <= RELEASE;
          end
        end
        ABORT: begin
          if (Tx_Done) begin
            Aborted <= Grant;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          lastServed <= gIdx;
          Grant      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Directed bench for hdlc_tx_scheduler: table of single-requester frames
// plus hand-written sequences for arbitration, back-pressure, abort, reset.
module tb_hdlc_tx_scheduler;

  localparam int N = 4;

  logic              Clk;
  logic              Rst;
  logic [N-1:0]      Req;
  logic [N-1:0][6:0] ReqLen;
  logic [N-1:0][7:0] ReqData;
  logic [N-1:0]      ReqValid;
  logic [N-1:0]      ReqReady;
  logic [N-1:0]      ReqAbort;
  logic [N-1:0]      Grant;
  logic [N-1:0]      Done;
  logic [N-1:0]      Aborted;
  logic [N-1:0]      Err;
  logic              Tx_WrBuff;
  logic [7:0]        Tx_DataIn;
  logic              Tx_Full;
  logic              Tx_Enable;
  logic              Tx_AbortFrame;
  logic              Tx_Done;

  hdlc_tx_scheduler #(
    .NUM_REQ  (N),
    .MAX_FRAME(126)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Req          (Req),
    .ReqLen       (ReqLen),
    .ReqData      (ReqData),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqAbort     (ReqAbort),
    .Grant        (Grant),
    .Done         (Done),
    .Aborted      (Aborted),
    .Err          (Err),
    .Tx_WrBuff    (Tx_WrBuff),
    .Tx_DataIn    (Tx_DataIn),
    .Tx_Full      (Tx_Full),
    .Tx_Enable    (Tx_Enable),
    .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_Done      (Tx_Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         req;
    int         len;
    int         base;
    int         busy;
    int         expWr;
    int         expEn;
    logic [3:0] expDone;
    logic [3:0] expErr;
  } vec_t;

  vec_t vecs[6];

  int passCnt = 0;
  int totalCnt = 0;

  // requester / transmitter models
  int   lenA[N];
  int   baseA[N];
  int   ptr[N];
  bit   active[N];
  bit   repeatReq[N];
  int   txBusy = 1;
  int   txLeft = 0;
  logic [N-1:0] xferSeen = '0;
  logic [N-1:0] evtSeen = '0;
  logic         enSeen = 1'b0;

  // observation stats
  int   cyc = 0;
  int   wrCount, wrFull, readyFull, badReady, multiGrant;
  int   enCount, afCount, doneCount;
  int   lastWrCycle, enCycle, afCycle, doneCycle, txRiseCycle, abortCycle;
  logic [N-1:0] doneMask, abortedMask, errMask, prevGrant;
  logic prevTxDone = 1'b1;
  logic [7:0] wrBytes[$];
  int   errLog[$];
  int   grantLog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int qAt(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic clearStats();
    wrCount = 0; wrFull = 0; readyFull = 0; badReady = 0; multiGrant = 0;
    enCount = 0; afCount = 0; doneCount = 0;
    lastWrCycle = -1; enCycle = -1; afCycle = -1; doneCycle = -1;
    txRiseCycle = -1; abortCycle = -1;
    doneMask = '0; abortedMask = '0; errMask = '0;
    wrBytes.delete(); errLog.delete(); grantLog.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      Req[i]      = active[i];
      ReqLen[i]   = 7'(lenA[i]);
      ReqValid[i] = active[i] && (ptr[i] < lenA[i]);
      ReqData[i]  = 8'(baseA[i] + ptr[i] * 17);
    end
  endtask

  task automatic sample();
    cyc++;
    if ($countones(Grant) > 1) multiGrant++;
    if ((ReqReady & ~Grant) != '0) badReady++;
    if (Tx_Full && ReqReady != '0) readyFull++;
    if (Tx_WrBuff) begin
      wrCount++;
      wrBytes.push_back(Tx_DataIn);
      lastWrCycle = cyc;
      if (Tx_Full) wrFull++;
    end
    if (Tx_Enable) begin enCount++; enCycle = cyc; end
    if (Tx_AbortFrame) begin afCount++; afCycle = cyc; end
    if (Tx_Done && !prevTxDone) txRiseCycle = cyc;
    prevTxDone = Tx_Done;
    if (Done != '0) begin doneCount++; doneCycle = cyc; end
    if ((ReqAbort & Grant) != '0 && abortCycle < 0) abortCycle = cyc;
    doneMask    = doneMask | Done;
    abortedMask = abortedMask | Aborted;
    errMask     = errMask | Err;
    for (int i = 0; i < N; i++) if (Err[i]) errLog.push_back(i);
    if (Grant != '0 && prevGrant == '0) begin
      for (int i = 0; i < N; i++) if (Grant[i]) grantLog.push_back(i);
    end
    prevGrant = Grant;
    xferSeen  = ReqValid & ReqReady;
    evtSeen   = Done | Aborted | Err;
    enSeen    = Tx_Enable;
  endtask

  // One clock: observe at the falling edge, then update models after the rising edge.
  task automatic step();
    @(negedge Clk);
    sample();
    @(posedge Clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xferSeen[i]) ptr[i]++;
      if (evtSeen[i]) begin
        if (repeatReq[i]) ptr[i] = 0;
        else active[i] = 1'b0;
      end
    end
    if (enSeen) begin
      txLeft  = txBusy;
      Tx_Done = 1'b0;
    end else if (txLeft > 0) begin
      txLeft--;
      if (txLeft == 0) Tx_Done = 1'b1;
    end
    drive();
  endtask

  task automatic setupReq(input int i, input int len, input int base, input bit rep);
    lenA[i] = len; baseA[i] = base; ptr[i] = 0; active[i] = 1'b1; repeatReq[i] = rep;
  endtask

  task automatic waitEvt(input logic [N-1:0] mask, input int budget, input string name);
    int n = 0;
    while (((doneMask | abortedMask | errMask) & mask) != mask && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  function automatic int byteErrs(input int base);
    int e = 0;
    for (int k = 0; k < wrBytes.size(); k++)
      if (wrBytes[k] != 8'(base + k * 17)) e++;
    return e;
  endfunction

  initial begin
    vecs[0] = '{req: 1, len: 3,   base: 'hA1, busy: 20, expWr: 3,   expEn: 1, expDone: 4'b0010, expErr: 4'b0000};
    vecs[1] = '{req: 0, len: 1,   base: 'h05, busy: 1,  expWr: 1,   expEn: 1, expDone: 4'b0001, expErr: 4'b0000};
    vecs[2] = '{req: 2, len: 126, base: 'h10, busy: 3,  expWr: 126, expEn: 1, expDone: 4'b0100, expErr: 4'b0000};
    vecs[3] = '{req: 1, len: 127, base: 'h00, busy: 1,  expWr: 0,   expEn: 0, expDone: 4'b0000, expErr: 4'b0010};
    vecs[4] = '{req: 2, len: 0,   base: 'h00, busy: 1,  expWr: 0,   expEn: 0, expDone: 4'b0000, expErr: 4'b0100};
    vecs[5] = '{req: 3, len: 7,   base: 'h3C, busy: 5,  expWr: 7,   expEn: 1, expDone: 4'b1000, expErr: 4'b0000};

    Rst = 1'b1; Tx_Full = 1'b0; Tx_Done = 1'b1; ReqAbort = '0; prevGrant = '0;
    for (int i = 0; i < N; i++) begin
      lenA[i] = 0; baseA[i] = 0; ptr[i] = 0; active[i] = 1'b0; repeatReq[i] = 1'b0;
    end
    drive();
    clearStats();
    repeat (2) step();
    check("reset_outputs", 32'({Grant, Done, Aborted, Err, ReqReady, Tx_WrBuff, Tx_DataIn, Tx_Enable, Tx_AbortFrame}), 32'd0);
    Rst = 1'b0;
    repeat (2) step();
    check("idle_no_grant", 32'(Grant), 32'd0);

    // Two malformed requests at once: requester 0 is searched first after reset.
    clearStats();
    setupReq(0, 0, 0, 1'b0);
    setupReq(3, 127, 0, 1'b0);
    drive();
    waitEvt(4'b1001, 60, "errpair");
    repeat (3) step();
    check("errpair_first", 32'(qAt(errLog, 0)), 32'd0);
    check("errpair_second", 32'(qAt(errLog, 1)), 32'd3);
    check("errpair_count", 32'(errLog.size()), 32'd2);
    check("errpair_writes", 32'(wrCount), 32'd0);
    check("errpair_enable", 32'(enCount), 32'd0);
    check("errpair_grant", 32'(grantLog.size()), 32'd0);

    // Table of single-requester frames.
    for (int v = 0; v < 6; v++) begin
      clearStats();
      txBusy = vecs[v].busy;
      setupReq(vecs[v].req, vecs[v].len, vecs[v].base, 1'b0);
      drive();
      waitEvt(4'(1 << vecs[v].req), 400, $sformatf("v%0d", v));
      repeat (4) step();
      check($sformatf("v%0d_writes", v), 32'(wrCount), 32'(vecs[v].expWr));
      check($sformatf("v%0d_enables", v), 32'(enCount), 32'(vecs[v].expEn));
      check($sformatf("v%0d_done", v), 32'(doneMask), 32'(vecs[v].expDone));
      check($sformatf("v%0d_err", v), 32'(errMask), 32'(vecs[v].expErr));
      check($sformatf("v%0d_bytes", v), 32'(byteErrs(vecs[v].base)), 32'd0);
      if (vecs[v].expEn != 0) begin
        check($sformatf("v%0d_en_lat", v), 32'(enCycle - lastWrCycle), 32'd1);
        check($sformatf("v%0d_done_lat", v), 32'(doneCycle - txRiseCycle), 32'd1);
      end
    end

    // Round robin with all four requesting back to back.
    clearStats();
    txBusy = 2;
    for (int i = 0; i < N; i++) setupReq(i, 2, i * 64, 1'b1);
    drive();
    begin
      int n = 0;
      while (grantLog.size() < 5 && n < 400) begin step(); n++; end
      check("rr_grant_timeout", 32'(n < 400), 32'd1);
    end
    for (int i = 0; i < N; i++) begin
      repeatReq[i] = 1'b0;
      if (!Grant[i]) active[i] = 1'b0;
    end
    drive();
    begin
      int n = 0;
      while (doneCount < 5 && n < 200) begin step(); n++; end
      check("rr_done_timeout", 32'(n < 200), 32'd1);
    end
    repeat (4) step();
    check("rr_g0", 32'(qAt(grantLog, 0)), 32'd0);
    check("rr_g1", 32'(qAt(grantLog, 1)), 32'd1);
    check("rr_g2", 32'(qAt(grantLog, 2)), 32'd2);
    check("rr_g3", 32'(qAt(grantLog, 3)), 32'd3);
    check("rr_g4", 32'(qAt(grantLog, 4)), 32'd0);
    check("rr_onehot", 32'(multiGrant), 32'd0);
    check("rr_done_count", 32'(doneCount), 32'd5);
    check("rr_en_eq_done", 32'(enCount), 32'(doneCount));
    check("rr_ready_owner", 32'(badReady), 32'd0);

    // Back-pressure: Tx_Full held for 5 cycles in the middle of a max frame.
    clearStats();
    txBusy = 3;
    setupReq(2, 126, 'h20, 1'b0);
    drive();
    begin
      int n = 0;
      while (wrCount < 60 && n < 200) begin step(); n++; end
      check("full_reach_timeout", 32'(n < 200), 32'd1);
    end
    Tx_Full = 1'b1;
    repeat (5) step();
    Tx_Full = 1'b0;
    waitEvt(4'b0100, 300, "full");
    repeat (3) step();
    check("full_writes", 32'(wrCount), 32'd126);
    check("full_wr_while_full", 32'(wrFull), 32'd0);
    check("full_ready_while_full", 32'(readyFull), 32'd0);
    check("full_bytes", 32'(byteErrs('h20)), 32'd0);
    check("full_enables", 32'(enCount), 32'd1);
    check("full_en_lat", 32'(enCycle - lastWrCycle), 32'd1);

    // Abort after 4 of 10 bytes.
    clearStats();
    txBusy = 3;
    setupReq(1, 10, 'h70, 1'b0);
    drive();
    begin
      int n = 0;
      while (wrCount < 4 && n < 100) begin step(); n++; end
      check("abort_reach_timeout", 32'(n < 100), 32'd1);
    end
    ReqAbort[1] = 1'b1;
    waitEvt(4'b0010, 100, "abort");
    ReqAbort[1] = 1'b0;
    repeat (3) step();
    check("abort_writes", 32'(wrCount), 32'd4);
    check("abort_af_count", 32'(afCount), 32'd1);
    check("abort_af_lat", 32'(afCycle - abortCycle), 32'd1);
    check("abort_aborted", 32'(abortedMask), 32'h2);
    check("abort_no_done", 32'(doneMask), 32'd0);
    check("abort_no_enable", 32'(enCount), 32'd0);

    // Asynchronous reset while waiting for the transmitter.
    clearStats();
    txBusy = 30;
    setupReq(1, 2, 'h40, 1'b0);
    drive();
    begin
      int n = 0;
      while (enCount < 1 && n < 50) begin step(); n++; end
      check("rst_reach_timeout", 32'(n < 50), 32'd1);
    end
    repeat (3) step();
    check("rst_pre_grant", 32'(Grant), 32'h2);
    #2;
    Rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'({Grant, Done, Aborted, Err, ReqReady, Tx_WrBuff, Tx_DataIn, Tx_Enable, Tx_AbortFrame}), 32'd0);
    for (int i = 0; i < N; i++) begin active[i] = 1'b0; ptr[i] = 0; end
    txLeft = 0;
    Tx_Done = 1'b1;
    drive();
    repeat (2) step();
    Rst = 1'b0;
    step();
    clearStats();
    setupReq(1, 2, 'h50, 1'b0);
    setupReq(0, 2, 'h60, 1'b0);
    txBusy = 2;
    drive();
    waitEvt(4'b0011, 200, "rst_after");
    repeat (3) step();
    check("rst_first_grant", 32'(qAt(grantLog, 0)), 32'd0);
    check("rst_second_grant", 32'(qAt(grantLog, 1)), 32'd1);
    check("rst_done_count", 32'(doneCount), 32'd2);
    check("rst_no_abortframe", 32'(afCount), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
